// File: rtl/adc_ltc2315.sv
// SPI read-out master for the LTC2315 12-bit ADC: frames CS/SCK, shifts SDO in MSB first, strobes en per result.
// Define ADC_RAW_FRAME_EN to present the full 16-bit raw frame on adc_data instead of the 12-bit result.
module adc_ltc2315 #(
  parameter int SCK_HALF   = 2,
  parameter int CS_SETUP   = 1,
  parameter int CS_QUIET   = 2,
  parameter int FRAME_BITS = 16
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        start,
  output logic        sck,
  output logic        CS,
  input  logic        sdo,
  output logic        en,
  output logic [15:0] adc_data
);

  localparam int CNT_MAX_A = (SCK_HALF > CS_SETUP) ? SCK_HALF : CS_SETUP;
  localparam int CNT_MAX   = (CNT_MAX_A > CS_QUIET) ? CNT_MAX_A : CS_QUIET;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int BIT_W     = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCK_HALF - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(CS_QUIET - 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  // The newest sample comes straight from sdo at the load instant, so the
  // register only keeps the samples that are still needed before it.
`ifdef ADC_RAW_FRAME_EN
  localparam int SHIFT_W = 15;
`else
  localparam int SHIFT_W = 14;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    QUIET
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               sck_q, sck_d;
  logic               cs_q, cs_d;
  logic               en_q, en_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [15:0]        adc_q, adc_d;

  logic [SHIFT_W:0]   shift_in;
  logic [15:0]        frame_word;

  assign shift_in = {shift_q, sdo};

`ifdef ADC_RAW_FRAME_EN
  assign frame_word = shift_in;
`else
  assign frame_word = {4'b0000, shift_in[14:3]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    en_d    = 1'b0;
    shift_d = shift_q;
    adc_d   = adc_q;

    case (state_q)
      IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        cnt_d = '0;
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          shift_d = '0;
        end
      end

      SETUP: begin
        cs_d  = 1'b0;
        sck_d = 1'b0;
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Each SCK period is a low half then a high half; sdo is captured as
      // the high half ends, just before the falling edge.
      SHIFT: begin
        cs_d = 1'b0;
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d   = 1'b0;
            shift_d = shift_in[SHIFT_W-1:0];
            if (bit_q == BIT_LAST) begin
              state_d = DONE;
              cs_d    = 1'b1;
              en_d    = 1'b1;
              adc_d   = frame_word;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // The IDLE cycle counts toward the quiet time, so back-to-back frames
      // see CS high for DONE plus CS_QUIET cycles.
      DONE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        cnt_d = '0;
        if (CS_QUIET > 1) begin
          state_d = QUIET;
        end else begin
          state_d = IDLE;
        end
      end

      QUIET: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        if (cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      en_q    <= 1'b0;
      shift_q <= '0;
      adc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      en_q    <= en_d;
      shift_q <= shift_d;
      adc_q   <= adc_d;
    end
  end

  assign sck      = sck_q;
  assign CS       = cs_q;
  assign en       = en_q;
  assign adc_data = adc_q;

endmodule

// File: tb/tb_adc_ltc2315.sv
// Bench for adc_ltc2315: an LTC2315 pin model feeds sdo, a frame-position model predicts the pins.
module tb_adc_ltc2315;

   localparam int SCK_HALF   = 2;
   localparam int CS_SETUP   = 1;
   localparam int CS_QUIET   = 2;
   localparam int FRAME_BITS = 16;
   localparam int CS_LOW_CYC = CS_SETUP + 2 * SCK_HALF * FRAME_BITS;
   localparam int DONE_POS   = CS_LOW_CYC + 1;
   localparam int LAST_POS   = DONE_POS + CS_QUIET - 1;

   logic        clk100 = 1'b0;
   logic        resetN = 1'b0;
   logic        start = 1'b0;
   logic        sdo = 1'b0;
   logic        sck;
   logic        cs;
   logic        en;
   logic [15:0] adcData;

   int          sdoMode = 3;
   logic [15:0] frameWord = 16'h0000;
   int          bitIdx = 0;
   logic        adcPrevCs = 1'b1;
   logic        adcPrevSck = 1'b0;

   int          modelPos = 0;
   logic [15:0] modelAdc = 16'h0000;

   int          checks = 0;
   int          errors = 0;
   int          timeoutCount = 0;
   logic        litOn = 1'b0;
   logic [15:0] litAdc = 16'h0000;
   logic        gapCheck = 1'b0;

   logic        prevCs = 1'b1;
   logic        prevSck = 1'b0;
   int          csLowLen = 0;
   int          csHighLen = 0;
   int          lowLenDone = 0;
   int          sckRises = 0;

   adc_ltc2315 #(
      .SCK_HALF  (SCK_HALF),
      .CS_SETUP  (CS_SETUP),
      .CS_QUIET  (CS_QUIET),
      .FRAME_BITS(FRAME_BITS)
   ) dut (
      .clk_100 (clk100),
      .reset   (resetN),
      .start   (start),
      .sck     (sck),
      .CS      (cs),
      .sdo     (sdo),
      .en      (en),
      .adc_data(adcData)
   );

   // 100 MHz system clock.
   always #5 clk100 = ~clk100;

   // The result the design should present for a given raw 16-bit frame.
   function automatic logic [15:0] formatResult(input logic [15:0] raw);
`ifdef ADC_RAW_FRAME_EN
      return raw;
`else
      return {4'b0000, raw[14:3]};
`endif
   endfunction

   // The raw frame the ADC pin model puts on sdo in each mode.
   function automatic logic [15:0] frameFor(input int mode, input logic [15:0] word);
      if (mode == 1) return 16'hFFFF;
      if (mode == 2) return word;
      return 16'h0000;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Called on a falling clock edge: set the ADC mode and start level, then let cycles pass.
   task automatic applyStimulus(input int mode, input logic startLevel, input int cycles);
      sdoMode = mode;
      start = startLevel;
      repeat (cycles) @(negedge clk100);
   endtask

   task automatic waitForEn(input int maxCycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk100);
         if (en) seen = 1'b1;
      end
      if (!seen) timeoutCount++;
   endtask

   task automatic waitForCsLow(input int maxCycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk100);
         if (!cs) seen = 1'b1;
      end
      if (!seen) timeoutCount++;
   endtask

   task automatic waitForSckRises(input int count, input int maxCycles);
      int   rises;
      logic last;
      rises = 0;
      last = sck;
      for (int i = 0; i < maxCycles && rises < count; i++) begin
         @(negedge clk100);
         if (sck && !last) rises++;
         last = sck;
      end
      if (rises < count) timeoutCount++;
   endtask

   // LTC2315 pin model: leading zero appears when CS falls, each SCK falling
   // edge moves on to the next bit, MSB first.
   initial forever begin
      @(posedge clk100);
      #2;
      if (adcPrevCs && !cs) bitIdx = 15;
      else if (adcPrevSck && !sck && bitIdx > 0) bitIdx--;
      case (sdoMode)
         0: sdo = 1'b0;
         1: sdo = 1'b1;
         2: sdo = frameWord[bitIdx];
         default: sdo = ~sdo;
      endcase
      adcPrevCs = cs;
      adcPrevSck = sck;
   end

   // Frame position: 0 while idle, 1..65 with CS low, 66 the result cycle,
   // 67 the quiet cycle; the pins follow from the position. Compared a moment
   // after every rising edge, along with per-frame edge and length counts.
   initial forever begin
      logic expCs;
      logic expSck;
      logic expEn;
      @(posedge clk100);
      if (!resetN) begin
         modelPos = 0;
         modelAdc = 16'h0000;
      end else begin
         if (modelPos == 0) modelPos = start ? 1 : 0;
         else if (modelPos == LAST_POS) modelPos = 0;
         else modelPos = modelPos + 1;
         if (modelPos == DONE_POS) modelAdc = formatResult(frameFor(sdoMode, frameWord));
      end
      expCs = !(modelPos >= 1 && modelPos <= CS_LOW_CYC);
      expSck = (modelPos > CS_SETUP && modelPos <= CS_LOW_CYC) &&
               (((modelPos - CS_SETUP - 1) % (2 * SCK_HALF)) >= SCK_HALF);
      expEn = (modelPos == DONE_POS);
      #1;
      checkOutput("cs", 16'(cs), 16'(expCs));
      checkOutput("sck", 16'(sck), 16'(expSck));
      checkOutput("en", 16'(en), 16'(expEn));
      checkOutput("adc_data", adcData, modelAdc);
      checkOutput("no_timeout", 16'(timeoutCount), 16'd0);

      if (cs && !prevCs) begin
         lowLenDone = csLowLen;
         csLowLen = 0;
         csHighLen = 0;
      end
      if (!cs && prevCs) begin
         if (gapCheck) checkOutput("cs_gap", 16'(csHighLen), 16'd3);
         csHighLen = 0;
         sckRises = 0;
      end
      if (cs) csHighLen++;
      else csLowLen++;
      if (sck && !prevSck) sckRises++;
      if (en) begin
         checkOutput("frame_sck_rises", 16'(sckRises), 16'd16);
         checkOutput("frame_cs_low", 16'(lowLenDone), 16'd65);
         if (litOn) checkOutput("adc_literal", adcData, litAdc);
      end
      prevCs = cs;
      prevSck = sck;
   end

   // Directed scenarios.
   initial begin
      @(negedge clk100);
      applyStimulus(3, 1'b1, 10);
      applyStimulus(3, 1'b0, 2);
      resetN = 1'b1;
      applyStimulus(3, 1'b0, 5);

      $display("[TB] single frame, sdo high");
      litOn = 1'b1;
`ifdef ADC_RAW_FRAME_EN
      litAdc = 16'hFFFF;
`else
      litAdc = 16'h0FFF;
`endif
      applyStimulus(1, 1'b1, 1);
      applyStimulus(1, 1'b0, 0);
      waitForEn(200);
      applyStimulus(1, 1'b0, 10);

      $display("[TB] single frame, code A5C");
      frameWord = 16'h52E0;
`ifdef ADC_RAW_FRAME_EN
      litAdc = 16'h52E0;
`else
      litAdc = 16'h0A5C;
`endif
      applyStimulus(2, 1'b1, 1);
      applyStimulus(2, 1'b0, 0);
      waitForEn(200);
      applyStimulus(2, 1'b0, 10);

      $display("[TB] back-to-back frames, sdo low");
      litAdc = 16'h0000;
      applyStimulus(0, 1'b1, 0);
      waitForCsLow(20);
      gapCheck = 1'b1;
      waitForEn(200);
      waitForEn(200);
      waitForEn(200);
      start = 1'b0;
      gapCheck = 1'b0;
      applyStimulus(0, 1'b0, 20);

      $display("[TB] reset during shift");
      frameWord = 16'h52E0;
`ifdef ADC_RAW_FRAME_EN
      litAdc = 16'h52E0;
`else
      litAdc = 16'h0A5C;
`endif
      applyStimulus(2, 1'b1, 1);
      applyStimulus(2, 1'b0, 0);
      waitForSckRises(8, 100);
      @(negedge clk100);
      resetN = 1'b0;
      applyStimulus(2, 1'b0, 3);
      resetN = 1'b1;
      applyStimulus(2, 1'b0, 5);
      applyStimulus(2, 1'b1, 1);
      applyStimulus(2, 1'b0, 0);
      waitForEn(200);
      applyStimulus(2, 1'b0, 10);

      $display("[TB] start toggling during shift, code 3C9");
      frameWord = 16'h1E48;
`ifdef ADC_RAW_FRAME_EN
      litAdc = 16'h1E48;
`else
      litAdc = 16'h03C9;
`endif
      applyStimulus(2, 1'b1, 1);
      applyStimulus(2, 1'b0, 0);
      waitForSckRises(2, 100);
      for (int i = 0; i < 30; i++) applyStimulus(2, ~start, 1);
      applyStimulus(2, 1'b0, 0);
      waitForEn(200);
      applyStimulus(2, 1'b0, 20);

      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
